// File: rtl/mem_access_ctrl_pkg.sv
// Shared MemIO request codes and FSM state encoding
// for the memory access sequencer.
package mem_access_ctrl_pkg;

  localparam logic [1:0] MEMIO_NOP = 2'b00;
  localparam logic [1:0] MEMIO_RD  = 2'b01;
  localparam logic [1:0] MEMIO_WR  = 2'b10;
  localparam logic [1:0] MEMIO_GR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_WR_REQ = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Request-wait counter: clears outside a request, counts
// stalled cycles, flags the cycle where the limit is reached.
module mem_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // count stalled request cycles
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: latches ALU MemIO requests and runs the
// req/ack handshake. MEM_TIMEOUT_EN enables the request timeout abort.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        MemIO,
  input  logic [31:0]       ALUAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              ValidMemData,
  output logic              WrDone,
  output logic              Busy,
  output logic              MemErr,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData
);

  state_t state;

`ifdef MEM_TIMEOUT_EN
  logic in_req;
  logic to_hit;
  logic mem_err_q;

  assign in_req = (state == ST_RD_REQ)
               || (state == ST_WR_REQ);
  assign MemErr = mem_err_q;

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (Clk),
    .reset (Reset),
    .clr   (!in_req),
    .en    (in_req && !MemAck),
    .hit   (to_hit)
  );
`else
  logic unused_to;

  assign unused_to = (TIMEOUT_CYCLES == 0);
  assign MemErr    = 1'b0;
`endif

  // sequencer FSM with registered handshake and strobe outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      RdData       <= '0;
      ValidMemData <= 1'b0;
      WrDone       <= 1'b0;
      Busy         <= 1'b0;
      MemReq       <= 1'b0;
      MemWE        <= 1'b0;
      MemAddr      <= '0;
      MemWData     <= '0;
`ifdef MEM_TIMEOUT_EN
      mem_err_q    <= 1'b0;
`endif
    end else begin
      ValidMemData <= 1'b0;
      WrDone       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_err_q    <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          unique case (MemIO)
            MEMIO_RD: begin
              state   <= ST_RD_REQ;
              Busy    <= 1'b1;
              MemReq  <= 1'b1;
              MemWE   <= 1'b0;
              MemAddr <= ALUAddr[ADDR_W-1:0];
            end
            MEMIO_WR: begin
              state    <= ST_WR_REQ;
              Busy     <= 1'b1;
              MemReq   <= 1'b1;
              MemWE    <= 1'b1;
              MemAddr  <= ALUAddr[ADDR_W-1:0];
              MemWData <= WrData;
            end
            MEMIO_NOP, MEMIO_GR: begin
              state <= ST_IDLE;
            end
          endcase
        end
        ST_RD_REQ, ST_WR_REQ: begin
          if (MemAck) begin
            state  <= ST_DONE;
            MemReq <= 1'b0;
            if (state == ST_RD_REQ) begin
              RdData       <= MemRData;
              ValidMemData <= 1'b1;
            end else begin
              WrDone <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_hit) begin
            state     <= ST_DONE;
            MemReq    <= 1'b0;
            mem_err_q <= 1'b1;
            if (state == ST_RD_REQ) begin
              RdData       <= '0;
              ValidMemData <= 1'b1;
            end
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven
// through a memory responder, scoreboard checked by a monitor.
module tb_mem_access_ctrl;

  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  MemIO;
  logic [31:0] ALUAddr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        ValidMemData;
  logic        WrDone;
  logic        Busy;
  logic        MemErr;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  mem_access_ctrl #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .MemIO        (MemIO),
    .ALUAddr      (ALUAddr),
    .WrData       (WrData),
    .RdData       (RdData),
    .ValidMemData (ValidMemData),
    .WrDone       (WrDone),
    .Busy         (Busy),
    .MemErr       (MemErr),
    .MemReq       (MemReq),
    .MemWE        (MemWE),
    .MemAddr      (MemAddr),
    .MemWData     (MemWData),
    .MemAck       (MemAck),
    .MemRData     (MemRData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    int          exp_len;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        hold;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_len;
    logic        exp_err;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[$];

  int   nvec = 0;
  int   nerr = 0;
  logic mon_en = 1'b0;
  logic req_prev = 1'b0;
  int   req_len = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  // monitor: request bursts and completion strobes vs scoreboard
  always @(posedge Clk) begin
    #1;
    if (!mon_en) begin
      req_prev = 1'b0;
      req_len  = 0;
    end else begin
      if (MemReq) begin
        if (sbq.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("mem_addr", MemAddr, sbq[0].addr);
          chk("mem_we", 32'(MemWE), 32'(!sbq[0].is_rd));
          if (!sbq[0].is_rd)
            chk("mem_wdata", MemWData, sbq[0].wdata);
        end
        req_len++;
      end else if (req_prev) begin
        if (sbq.size() != 0)
          chk("req_len", req_len, sbq[0].exp_len);
        req_len = 0;
      end
      req_prev = MemReq;
      if (ValidMemData || WrDone || MemErr) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("valid_strobe", 32'(ValidMemData),
              32'(e.is_rd));
          chk("wrdone_strobe", 32'(WrDone),
              32'(!e.is_rd && !e.exp_err));
          chk("mem_err", 32'(MemErr), 32'(e.exp_err));
          if (e.is_rd)
            chk("rd_data", RdData, e.exp_rd);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   bc;
    @(negedge Clk);
    MemIO   = v.op;
    ALUAddr = v.addr;
    WrData  = v.wdata;
    e.is_rd   = (v.op == 2'b01);
    e.addr    = v.addr;
    e.wdata   = v.wdata;
    e.exp_rd  = v.exp_rd;
    e.exp_len = v.exp_len;
    e.exp_err = v.exp_err;
    sbq.push_back(e);
    @(negedge Clk);
    bc = 0;
    for (int c = 0; c < 60 && Busy; c++) begin
      bc++;
      if (v.hold && bc < v.exp_len) begin
        MemIO   = v.op;
        ALUAddr = v.addr + 32'h100;
      end else begin
        MemIO   = 2'b00;
        ALUAddr = $urandom;
      end
      WrData   = $urandom;
      MemAck   = (v.ack_at != 0) && (bc == v.ack_at);
      MemRData = MemAck ? v.rdata : $urandom;
      @(negedge Clk);
    end
    MemAck = 1'b0;
    MemIO  = 2'b00;
    chk("busy_len", bc, v.exp_len + 1);
  endtask

  initial begin
    // op addr wdata rdata ack_at exp_len exp_rd err hold
    vecs.push_back('{2'b01, 32'h10, 32'h0,
      32'hCAFE0001, 1, 1, 32'hCAFE0001, 0, 0});
    vecs.push_back('{2'b10, 32'h20, 32'h55AA,
      32'h0, 4, 4, 32'h0, 0, 0});
    vecs.push_back('{2'b01, 32'h40, 32'h0,
      32'h12345678, 3, 3, 32'h12345678, 0, 1});
    vecs.push_back('{2'b01, 32'hFFFF_FFFC, 32'h0,
      32'hDEADBEEF, 2, 2, 32'hDEADBEEF, 0, 0});
    vecs.push_back('{2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFF,
      32'h0, 1, 1, 32'h0, 0, 0});
    vecs.push_back('{2'b01, 32'h0, 32'h0,
      32'h0, 2, 2, 32'h0, 0, 0});
`ifdef MEM_TIMEOUT_EN
    vecs.push_back('{2'b01, 32'h80, 32'h0,
      32'hA5A5A5A5, 2, 2, 32'hA5A5A5A5, 0, 0});
    vecs.push_back('{2'b01, 32'h84, 32'h0,
      32'h0, 0, TO, 32'h0, 1, 0});
    vecs.push_back('{2'b01, 32'h88, 32'h0,
      32'h600DF00D, TO, TO, 32'h600DF00D, 0, 0});
`endif

    Reset    = 1'b1;
    MemIO    = 2'b00;
    ALUAddr  = '0;
    WrData   = '0;
    MemAck   = 1'b0;
    MemRData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_rddata", RdData, 32'h0);
    chk("rst_valid", 32'(ValidMemData), 32'h0);
    chk("rst_wrdone", 32'(WrDone), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_memerr", 32'(MemErr), 32'h0);
    chk("rst_memreq", 32'(MemReq), 32'h0);
    chk("rst_memwe", 32'(MemWE), 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    Reset  = 1'b0;
    mon_en = 1'b1;

    // GPR code and stray ack in IDLE do nothing
    @(negedge Clk);
    MemIO  = 2'b11;
    MemAck = 1'b1;
    repeat (2) @(negedge Clk);
    chk("gr_busy", 32'(Busy), 32'h0);
    chk("gr_memreq", 32'(MemReq), 32'h0);
    MemIO  = 2'b00;
    MemAck = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (2) @(negedge Clk);
    chk("sb_empty", sbq.size(), 32'h0);

    // reset in second write request cycle, ack arrives late
    mon_en = 1'b0;
    @(negedge Clk);
    MemIO   = 2'b10;
    ALUAddr = 32'h30;
    WrData  = 32'h1111;
    @(negedge Clk);
    MemIO = 2'b00;
    chk("rmo_req1", 32'(MemReq), 32'h1);
    @(negedge Clk);
    chk("rmo_req2", 32'(MemReq), 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset  = 1'b0;
    MemAck = 1'b1;
    chk("rmo_memreq", 32'(MemReq), 32'h0);
    chk("rmo_busy", 32'(Busy), 32'h0);
    chk("rmo_wrdone", 32'(WrDone), 32'h0);
    @(negedge Clk);
    MemAck = 1'b0;
    chk("rmo_wrdone2", 32'(WrDone), 32'h0);
    chk("rmo_busy2", 32'(Busy), 32'h0);
    chk("rmo_memreq2", 32'(MemReq), 32'h0);
    chk("rmo_rddata", RdData, 32'h0);
    @(negedge Clk);
    chk("rmo_busy3", 32'(Busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
